imem_arbiter: RTL and testbench

IMEM_ARBITER -- requirements
Module: imem_arbiter

---
 rtl/imem_arbiter_pkg.sv | 21 ++
 rtl/imem_arbiter_starve.sv | 37 +++
 rtl/imem_arbiter.sv | 126 ++++++++++++
 tb/tb_imem_arbiter.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// Shared constants for the instruction-memory arbiter: FSM encodings,
// memory geometry and the instruction constants the fetch side reuses.
package imem_arbiter_pkg;

   localparam logic [1:0] ST_BOOT = 2'd0;
   localparam logic [1:0] ST_LOAD = 2'd1;
   localparam logic [1:0] ST_GO   = 2'd2;
   localparam logic [1:0] ST_RUN  = 2'd3;

   localparam int         MEM_DEPTH    = 64;
   localparam logic [6:0] LD_COUNT_MAX = 7'(MEM_DEPTH);

   // RV32I OP-IMM opcode and the canonical NOP (addi x0, x0, 0)
   localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
   localparam logic [31:0] INSN_NOP   = 32'h0000_0013;

   function automatic logic [7:0] word_addr(input logic [5:0] w);
      return {2'b00, w};
   endfunction

endpackage

// File: rtl/imem_arbiter_starve.sv
// Counts consecutive cycles a pending debug read loses to fetch and flags
// when it has waited STARVE_MAX cycles so the arbiter can force a grant.
module starve_counter #(
   parameter int STARVE_MAX = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic active,
   input  logic dbg_req,
   input  logic dbg_grant,
   output logic at_max
);

   localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

   logic [CW-1:0] count_reg, count_next;

   // Only RUN-time denials count; loader phases leave debug idle by design.
   always_comb begin
      count_next = count_reg;
      if (!active || !dbg_req || dbg_grant)
         count_next = '0;
      else if (count_reg != CNT_MAX)
         count_next = count_reg + CW'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         count_reg <= '0;
      else
         count_reg <= count_next;
   end

   assign at_max = (count_reg == CNT_MAX);

endmodule

// File: rtl/imem_arbiter.sv
// Instruction memory arbiter: boots the program image from the loader,
// pulses start, then shares the read port between fetch and debug.
module imem_arbiter
   import imem_arbiter_pkg::*;
#(
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        fetch_req,
   input  logic [7:0]  fetch_addr,
   output logic        fetch_stall,
   input  logic        ld_valid,
   input  logic [31:0] ld_data,
   input  logic        ld_last,
   output logic        ld_ready,
   input  logic        dbg_req,
   input  logic [5:0]  dbg_addr,
   output logic        dbg_ready,
   output logic        dbg_rvalid,
   output logic [31:0] dbg_rdata,
   output logic [7:0]  mem_address,
   output logic [31:0] mem_data,
   output logic        mem_wren,
   input  logic [31:0] mem_q,
   output logic        start,
   output logic [6:0]  ld_count,
   output logic        ld_overflow
);

   logic [1:0]  state_reg, state_next;
   logic [6:0]  count_reg, count_next;
   logic        overflow_reg, overflow_next;
   logic        rvalid_reg;
   logic [31:0] rdata_reg;

   logic in_run, in_load, ld_full, ld_accept;
   logic starve_max, dbg_grant, fetch_grant;
   logic unused_byte_offset;

   assign unused_byte_offset = ^fetch_addr[1:0];

   assign in_run    = (state_reg == ST_RUN);
   assign in_load   = (state_reg == ST_BOOT) || (state_reg == ST_LOAD);
   assign ld_full   = (count_reg == LD_COUNT_MAX);
   assign ld_accept = !rst && in_load && ld_valid;

   // Fetch wins unless debug has been starved long enough.
   assign dbg_grant   = !rst && in_run && dbg_req && (!fetch_req || starve_max);
   assign fetch_grant = !rst && in_run && fetch_req && !dbg_grant;

   starve_counter #(
      .STARVE_MAX (STARVE_MAX)
   ) u_starve (
      .clk       (clk),
      .rst       (rst),
      .active    (in_run),
      .dbg_req   (dbg_req),
      .dbg_grant (dbg_grant),
      .at_max    (starve_max)
   );

   always_comb begin
      state_next    = state_reg;
      count_next    = count_reg;
      overflow_next = overflow_reg;
      case (state_reg)
         ST_BOOT, ST_LOAD: begin
            if (ld_valid) begin
               if (ld_full)
                  overflow_next = 1'b1;
               else
                  count_next = count_reg + 7'd1;
               state_next = ld_last ? ST_GO : ST_LOAD;
            end
         end
         ST_GO:   state_next = ST_RUN;
         default: state_next = state_reg;
      endcase
   end

   // BOOT shares the LOAD write path: ld_count is 0 there, so word 0 is hit.
   always_comb begin
      mem_address = '0;
      mem_data    = '0;
      mem_wren    = 1'b0;
      if (ld_accept) begin
         if (!ld_full) begin
            mem_wren    = 1'b1;
            mem_address = {1'b0, count_reg};
            mem_data    = ld_data;
         end
      end else if (dbg_grant) begin
         mem_address = word_addr(dbg_addr);
      end else if (fetch_grant) begin
         mem_address = word_addr(fetch_addr[7:2]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg    <= ST_BOOT;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         rvalid_reg   <= 1'b0;
         rdata_reg    <= '0;
      end else begin
         state_reg    <= state_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_next;
         rvalid_reg   <= dbg_grant;
         if (rvalid_reg)
            rdata_reg <= mem_q;
      end
   end

   assign ld_ready    = !rst && in_load;
   assign fetch_stall = rst || !in_run || (fetch_req && dbg_grant);
   assign dbg_ready   = dbg_grant;
   assign dbg_rvalid  = rvalid_reg;
   assign dbg_rdata   = rvalid_reg ? mem_q : rdata_reg;
   assign start       = (state_reg == ST_GO);
   assign ld_count    = count_reg;
   assign ld_overflow = overflow_reg;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with a behavioural memory and scoreboards
// for expected memory writes and expected debug read data.
module tb_imem_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        fetch_req;
   logic [7:0]  fetch_addr;
   logic        fetch_stall;
   logic        ld_valid;
   logic [31:0] ld_data;
   logic        ld_last;
   logic        ld_ready;
   logic        dbg_req;
   logic [5:0]  dbg_addr;
   logic        dbg_ready;
   logic        dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic [7:0]  mem_address;
   logic [31:0] mem_data;
   logic        mem_wren;
   logic [31:0] mem_q;
   logic        start;
   logic [6:0]  ld_count;
   logic        ld_overflow;

   always #5 clk = ~clk;

   imem_arbiter #(.STARVE_MAX(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .fetch_req   (fetch_req),
      .fetch_addr  (fetch_addr),
      .fetch_stall (fetch_stall),
      .ld_valid    (ld_valid),
      .ld_data     (ld_data),
      .ld_last     (ld_last),
      .ld_ready    (ld_ready),
      .dbg_req     (dbg_req),
      .dbg_addr    (dbg_addr),
      .dbg_ready   (dbg_ready),
      .dbg_rvalid  (dbg_rvalid),
      .dbg_rdata   (dbg_rdata),
      .mem_address (mem_address),
      .mem_data    (mem_data),
      .mem_wren    (mem_wren),
      .mem_q       (mem_q),
      .start       (start),
      .ld_count    (ld_count),
      .ld_overflow (ld_overflow)
   );

   // Synchronous RAM with one-cycle read latency
   logic [31:0] mem [0:63];
   always @(posedge clk) begin
      if (mem_wren)
         mem[mem_address[5:0]] <= mem_data;
      mem_q <= mem[mem_address[5:0]];
   end

   typedef struct packed {
      logic [7:0]  addr;
      logic [31:0] data;
   } wr_t;

   wr_t         wr_q[$];
   logic [31:0] rd_q[$];
   logic [31:0] shadow [0:63];
   int          exp_count = 0;
   int          tests = 0;
   int          fails = 0;
   wr_t         mon_w;
   logic [31:0] mon_d;
   logic [31:0] prog3 [0:2] = '{32'h13, 32'h33, 32'h63};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   task automatic drive_word(input logic [31:0] d, input logic last);
      ld_valid = 1'b1;
      ld_data  = d;
      ld_last  = last;
      if (exp_count < 64) begin
         wr_q.push_back(wr_t'{addr: 8'(exp_count), data: d});
         shadow[exp_count] = d;
         exp_count++;
      end
   endtask

   // Scoreboard consumer: every write and every debug return is matched
   always begin
      @(negedge clk);
      #3;
      if (mem_wren) begin
         if (wr_q.size() == 0) begin
            check("wr_pending", 32'(wr_q.size()), 32'd1);
         end else begin
            mon_w = wr_q.pop_front();
            check("wr_addr", 32'(mem_address), 32'(mon_w.addr));
            check("wr_data", mem_data, mon_w.data);
            $display("[TB] write addr=%0d data=%h", mem_address, mem_data);
         end
      end
      if (dbg_rvalid) begin
         if (rd_q.size() == 0) begin
            check("rd_pending", 32'(rd_q.size()), 32'd1);
         end else begin
            mon_d = rd_q.pop_front();
            check("dbg_rdata", dbg_rdata, mon_d);
            $display("[TB] debug read data=%h", dbg_rdata);
         end
      end
   end

   initial begin
      rst = 1'b1; fetch_req = 1'b0; fetch_addr = '0; ld_valid = 1'b0;
      ld_data = '0; ld_last = 1'b0; dbg_req = 1'b0; dbg_addr = '0;

      // Reset state, with a loader word presented that must not be written
      step(); ld_valid = 1'b1; ld_data = 32'h1234; #2;
      check("rst_ld_count", 32'(ld_count), 32'd0);
      check("rst_overflow", 32'(ld_overflow), 32'd0);
      check("rst_start", 32'(start), 32'd0);
      check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
      check("rst_rdata", dbg_rdata, 32'd0);
      check("rst_wren", 32'(mem_wren), 32'd0);
      check("rst_stall", 32'(fetch_stall), 32'd1);
      check("rst_dbg_ready", 32'(dbg_ready), 32'd0);
      step(); ld_valid = 1'b0; rst = 1'b0; #2;
      check("boot_ld_ready", 32'(ld_ready), 32'd1);

      // Three-word program
      for (int i = 0; i < 3; i++) begin
         step(); drive_word(prog3[i], (i == 2)); #2;
         check("load_ld_ready", 32'(ld_ready), 32'd1);
         check("load_start", 32'(start), 32'd0);
         check("load_count", 32'(ld_count), 32'(i));
         check("load_stall", 32'(fetch_stall), 32'd1);
      end
      step(); ld_valid = 1'b0; ld_last = 1'b0; #2;
      check("go_start", 32'(start), 32'd1);
      check("go_count", 32'(ld_count), 32'd3);
      check("go_stall", 32'(fetch_stall), 32'd1);
      check("go_dbg_ready", 32'(dbg_ready), 32'd0);
      check("go_wren", 32'(mem_wren), 32'd0);
      step(); #2;
      check("run_start", 32'(start), 32'd0);
      check("run_ld_ready", 32'(ld_ready), 32'd0);
      check("idle_addr", 32'(mem_address), 32'd0);
      check("idle_stall", 32'(fetch_stall), 32'd0);

      // Fetch address mapping
      step(); fetch_req = 1'b1; fetch_addr = 8'h0B; #2;
      check("fetch_0b", 32'(mem_address), 32'h02);
      check("fetch_0b_stall", 32'(fetch_stall), 32'd0);
      step(); fetch_addr = 8'hFF; #2;
      check("fetch_ff", 32'(mem_address), 32'h3F);

      // Loader ignored in RUN
      step(); fetch_req = 1'b0; ld_valid = 1'b1; ld_data = 32'hBAD; ld_last = 1'b1; #2;
      check("run_ld_ready_v", 32'(ld_ready), 32'd0);
      check("run_wren", 32'(mem_wren), 32'd0);
      step(); ld_valid = 1'b0; ld_last = 1'b0; #2;
      check("run_count_hold", 32'(ld_count), 32'd3);
      check("run_start_hold", 32'(start), 32'd0);

      // Uncontended debug read
      step(); dbg_req = 1'b1; dbg_addr = 6'd1; rd_q.push_back(shadow[1]); #2;
      check("dbg1_ready", 32'(dbg_ready), 32'd1);
      check("dbg1_addr", 32'(mem_address), 32'd1);
      check("dbg1_stall", 32'(fetch_stall), 32'd0);
      step(); dbg_req = 1'b0; #2;
      check("dbg1_rvalid", 32'(dbg_rvalid), 32'd1);
      step(); #2;
      check("dbg1_rvalid_off", 32'(dbg_rvalid), 32'd0);
      check("dbg1_rdata_hold", dbg_rdata, shadow[1]);

      // Reset in the middle of a load
      step(); rst = 1'b1; #2;
      check("rst_run_count", 32'(ld_count), 32'd0);
      step(); rst = 1'b0; exp_count = 0;
      for (int i = 0; i < 2; i++) begin
         step(); drive_word(32'hC000_0000 + 32'(i), 1'b0); #2;
         check("ml_wren", 32'(mem_wren), 32'd1);
      end
      step(); ld_data = 32'hDEAD_0000; rst = 1'b1; #2;
      check("ml_rst_wren", 32'(mem_wren), 32'd0);
      check("ml_rst_count", 32'(ld_count), 32'd0);
      step(); rst = 1'b0; ld_valid = 1'b0; exp_count = 0; #2;
      check("ml_boot_ready", 32'(ld_ready), 32'd1);
      check("ml_boot_count", 32'(ld_count), 32'd0);
      step(); drive_word(32'h0000_0093, 1'b1); #2;
      check("ml_word0_wren", 32'(mem_wren), 32'd1);
      step(); ld_valid = 1'b0; ld_last = 1'b0; #2;
      check("ml_go_start", 32'(start), 32'd1);
      check("ml_go_count", 32'(ld_count), 32'd1);
      step(); #2;
      check("ml_run_start", 32'(start), 32'd0);

      // 65-word program: the last word overflows
      step(); rst = 1'b1;
      step(); rst = 1'b0; exp_count = 0;
      for (int i = 0; i < 65; i++) begin
         step(); drive_word(32'hA500_0000 + 32'(i), (i == 64)); #2;
         if (i == 64) begin
            check("ovf_count_full", 32'(ld_count), 32'd64);
            check("ovf_pre_flag", 32'(ld_overflow), 32'd0);
            check("ovf_drop_wren", 32'(mem_wren), 32'd0);
         end
      end
      step(); ld_valid = 1'b0; ld_last = 1'b0; #2;
      check("ovf_start", 32'(start), 32'd1);
      check("ovf_flag", 32'(ld_overflow), 32'd1);
      check("ovf_count", 32'(ld_count), 32'd64);
      step(); #2;
      check("ovf_run_start", 32'(start), 32'd0);

      // Debug starvation under constant fetch
      for (int c = 0; c < 4; c++) begin
         step(); fetch_req = 1'b1; fetch_addr = 8'(8'h10 + 4 * c); dbg_req = 1'b1; dbg_addr = 6'd5; #2;
         check("starve_dbg_ready", 32'(dbg_ready), 32'd0);
         check("starve_stall", 32'(fetch_stall), 32'd0);
         check("starve_addr", 32'(mem_address), 32'(4 + c));
      end
      step(); fetch_addr = 8'h20; rd_q.push_back(shadow[5]); #2;
      check("forced_dbg_ready", 32'(dbg_ready), 32'd1);
      check("forced_stall", 32'(fetch_stall), 32'd1);
      check("forced_addr", 32'(mem_address), 32'd5);
      step(); dbg_req = 1'b0; #2;
      check("forced_rvalid", 32'(dbg_rvalid), 32'd1);
      check("forced_post_ready", 32'(dbg_ready), 32'd0);
      check("forced_post_stall", 32'(fetch_stall), 32'd0);
      step(); fetch_req = 1'b0; #2;
      check("forced_rvalid_off", 32'(dbg_rvalid), 32'd0);
      check("forced_rdata_hold", dbg_rdata, shadow[5]);
      check("run_count_64", 32'(ld_count), 32'd64);
      check("run_overflow_hold", 32'(ld_overflow), 32'd1);
      step(); #2;
      check("wr_queue_empty", 32'(wr_q.size()), 32'd0);
      check("rd_queue_empty", 32'(rd_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
